// File: rtl/hus_out.sv
// hus_out: stereo sample playback to an I2S-style DAC in left-justified format.
//
// Pulls 16-bit samples from a sample FIFO in L, R order, holds one stereo pair
// ahead of the pair currently being shifted out, and serialises it MSB first.
// One frame is 32 bit slots (16 left, 16 right) = 64*DIV clk cycles.
//
// Handshake: fifo_rd is a one-cycle read strobe, only raised while fifo_empty
// is low; the word it pops is presented on fifo_rd_data in the following
// cycle and is captured at the end of that cycle.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   en             playback enable; dropping it abandons the current frame
//   fifo_rd_data   sample word, valid the cycle after fifo_rd
//   fifo_empty     sample FIFO empty
//   underrun_clr   clears the sticky underrun flag
//   fifo_rd        FIFO read strobe
//   tick           one-cycle pulse at every frame start
//   dac_bck        DAC bit clock (DIV clk per half-period)
//   dac_lrck       DAC word select, 0 = left, 1 = right
//   dac_dat        DAC serial data, changes on dac_bck falling edge
//   underrun       sticky flag: a fetch found the FIFO empty
//   fsm_state      fetch FSM state, for observation only
module hus_out #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] fifo_rd_data,
    input  logic        fifo_empty,
    input  logic        underrun_clr,
    output logic        fifo_rd,
    output logic        tick,
    output logic        dac_bck,
    output logic        dac_lrck,
    output logic        dac_dat,
    output logic        underrun,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {IDLE, RD_L, CAP_L, RD_R, CAP_R, WAIT} state_t;

    localparam logic [7:0] DIV_TC = 8'(DIV - 1);

    state_t      state, state_next;
    logic        running;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [15:0] hold_l, hold_r, sh_l, sh_r;
    logic        rd_issued;

    logic        div_tc, fall, wrap_start, launch, frame_start, next_dat;
    logic [4:0]  bit_next;
    logic [3:0]  bit_idx;

    assign div_tc      = running && (div_cnt == DIV_TC);
    assign fall        = div_tc && dac_bck;
    assign bit_next    = bit_cnt + 5'd1;
    assign wrap_start  = fall && (bit_cnt == 5'd31);
    assign launch      = en && (state == WAIT) && !running;
    assign frame_start = launch || (en && wrap_start);
    assign tick        = frame_start;
    assign fsm_state   = state;

    // 15 - slot for the left half and 31 - slot for the right half are both
    // the inverted low nibble of the slot number.
    assign bit_idx = ~bit_next[3:0];

    // Slot 0 of a new frame comes from the holding register, because the
    // shift registers are reloaded on the same edge.
    always_comb begin
        next_dat = 1'b0;
        if (bit_next == 5'd0)
            next_dat = hold_l[15];
        else if (bit_next[4])
            next_dat = sh_r[bit_idx];
        else
            next_dat = sh_l[bit_idx];
    end

    always_comb begin
        state_next = state;
        fifo_rd    = 1'b0;
        case (state)
            IDLE:  if (en) state_next = RD_L;
            RD_L:  begin
                fifo_rd    = en && !fifo_empty;
                state_next = CAP_L;
            end
            CAP_L: state_next = RD_R;
            RD_R:  begin
                fifo_rd    = en && !fifo_empty;
                state_next = CAP_R;
            end
            CAP_R: state_next = WAIT;
            WAIT:  if (frame_start) state_next = RD_L;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            running   <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            dac_bck   <= 1'b0;
            dac_lrck  <= 1'b0;
            dac_dat   <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            sh_l      <= '0;
            sh_r      <= '0;
            rd_issued <= 1'b0;
        end else if (!en) begin
            // Abandon playback; holding and shift registers keep their data.
            state     <= IDLE;
            running   <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            dac_bck   <= 1'b0;
            dac_lrck  <= 1'b0;
            dac_dat   <= 1'b0;
            rd_issued <= 1'b0;
        end else begin
            state     <= state_next;
            rd_issued <= fifo_rd;
            // A fetch that found the FIFO empty plays silence on that channel.
            if (state == CAP_L) hold_l <= rd_issued ? fifo_rd_data : 16'h0000;
            if (state == CAP_R) hold_r <= rd_issued ? fifo_rd_data : 16'h0000;

            if (launch) begin
                running  <= 1'b1;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                dac_bck  <= 1'b0;
                dac_lrck <= 1'b0;
                dac_dat  <= hold_l[15];
                sh_l     <= hold_l;
                sh_r     <= hold_r;
            end else if (running) begin
                if (div_tc) begin
                    div_cnt <= '0;
                    dac_bck <= ~dac_bck;
                    if (fall) begin
                        bit_cnt  <= bit_next;
                        dac_lrck <= bit_next[4];
                        dac_dat  <= next_dat;
                        if (wrap_start) begin
                            sh_l <= hold_l;
                            sh_r <= hold_r;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset)
            underrun <= 1'b0;
        else if (en && (state == RD_L || state == RD_R) && fifo_empty)
            underrun <= 1'b1;
        else if (underrun_clr)
            underrun <= 1'b0;
    end

    // The next pair must already be prefetched whenever a frame wraps.
    a_wrap_in_wait: assert property (@(posedge clk) disable iff (reset)
        (en && wrap_start) |-> (state == WAIT));

endmodule

// File: tb/tb_hus_out.sv
// tb_hus_out: drives two hus_out instances (DIV=2 and DIV=4), each fed by a
// behavioural sample FIFO, and checks frames, ticks, reads and underrun.
module tb_hus_out;

    localparam int DIV0 = 2;
    localparam int DIV1 = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  en, underrun_clr, fifo_empty;
    logic [1:0]  fifo_rd, tick, dac_bck, dac_lrck, dac_dat, underrun;
    logic [15:0] rd_data [2];
    logic [2:0]  st [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- FIFO model and monitors ----------------
    logic [15:0] fmem [2][0:15];
    int          fbase [2] = '{0, 0};
    int          fcnt  [2] = '{0, 0};
    int          pops  [2] = '{0, 0};
    logic        pend  [2] = '{1'b0, 1'b0};

    int          tn [2] = '{0, 0};
    int          tlog [2][0:255];
    int          last_tick [2] = '{-1, -1};
    int          rdn [2] = '{0, 0};
    int          bad_rd [2] = '{0, 0};
    int          late_rd [2] = '{0, 0};
    logic [15:0] lsr [2], rsr [2];
    int          lc [2] = '{0, 0};
    int          rc [2] = '{0, 0};
    logic [31:0] cap [2][0:255];
    int          ncap [2] = '{0, 0};
    logic        bck_prev [2] = '{1'b0, 1'b0};

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hus_out #(.DIV(g == 0 ? DIV0 : DIV1)) dut (
            .clk          (clk),
            .reset        (reset),
            .en           (en[g]),
            .fifo_rd_data (rd_data[g]),
            .fifo_empty   (fifo_empty[g]),
            .underrun_clr (underrun_clr[g]),
            .fifo_rd      (fifo_rd[g]),
            .tick         (tick[g]),
            .dac_bck      (dac_bck[g]),
            .dac_lrck     (dac_lrck[g]),
            .dac_dat      (dac_dat[g]),
            .underrun     (underrun[g]),
            .fsm_state    (st[g])
        );

        assign fifo_empty[g] = (pops[g] - fbase[g]) >= fcnt[g];

        always @(posedge clk) if (pend[g]) pops[g] <= pops[g] + 1;

        always @(negedge clk) begin
            pend[g] = fifo_rd[g];
            if (fifo_rd[g]) begin
                rdn[g]++;
                if (fifo_empty[g]) bad_rd[g]++;
                if (last_tick[g] >= 0 && cyc - last_tick[g] != 1 && cyc - last_tick[g] != 3)
                    late_rd[g]++;
                rd_data[g] = fmem[g][(pops[g] - fbase[g]) & 15];
            end
            if (tick[g]) begin
                tlog[g][tn[g] % 256] = cyc;
                tn[g]++;
                last_tick[g] = cyc;
            end
            if (!en[g]) begin
                lc[g] = 0;
                rc[g] = 0;
                last_tick[g] = -1;
            end else if (dac_bck[g] && !bck_prev[g]) begin
                if (!dac_lrck[g]) begin
                    lsr[g] = {lsr[g][14:0], dac_dat[g]};
                    lc[g]++;
                end else begin
                    rsr[g] = {rsr[g][14:0], dac_dat[g]};
                    rc[g]++;
                    if (rc[g] == 16) begin
                        cap[g][ncap[g] % 256] = {lsr[g], rsr[g]};
                        ncap[g]++;
                        lc[g] = 0;
                        rc[g] = 0;
                    end
                end
            end
            bck_prev[g] = dac_bck[g];
        end
    end

    // ---------------- scoreboard ----------------
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int g, input int n, input bit fixed);
        for (int i = 0; i < 16; i++) fmem[g][i] = 16'($urandom);
        if (fixed) begin
            fmem[g][0] = 16'hA5F0;
            fmem[g][1] = 16'h0F0F;
        end
        fbase[g] = pops[g];
        fcnt[g]  = n;
    endtask

    // Plays n queued words for nframes frames and checks everything observable.
    task automatic run_stream(input int g, input int n, input int nframes,
                              input bit fixed, input bit clr_at_rdl);
        int d, c0, t0, r0, b0, l0, k0, target, exp_rd, attempts;
        logic [15:0] el, er;
        d = (g == 0) ? DIV0 : DIV1;
        load(g, n, fixed);
        underrun_clr[g] = 1'b1;
        step();
        underrun_clr[g] = 1'b0;
        sample();
        chk("ur_clr", 32'(underrun[g]), 0);
        step();
        t0 = tn[g]; r0 = rdn[g]; b0 = bad_rd[g]; l0 = late_rd[g]; k0 = ncap[g];
        en[g] = 1'b1;
        c0 = cyc;
        step();
        if (clr_at_rdl) underrun_clr[g] = 1'b1;
        sample();
        chk("ur_before", 32'(underrun[g]), 0);
        step();
        underrun_clr[g] = 1'b0;
        sample();
        chk("ur_after_rdl", 32'(underrun[g]), 32'(n == 0));
        target = c0 + 5 + nframes * 64 * d - 1;
        repeat (target - cyc) step();
        sample();
        attempts = 2 * (nframes + 1);
        exp_rd = (n < attempts) ? n : attempts;
        chk("tick_cnt", 32'(tn[g] - t0), 32'(nframes));
        for (int k = 0; k < nframes && k < tn[g] - t0; k++)
            chk("tick_at", 32'(tlog[g][(t0 + k) % 256]), 32'(c0 + 5 + k * 64 * d));
        chk("rd_cnt", 32'(rdn[g] - r0), 32'(exp_rd));
        chk("rd_empty", 32'(bad_rd[g] - b0), 0);
        chk("rd_window", 32'(late_rd[g] - l0), 0);
        chk("frame_cnt", 32'(ncap[g] - k0), 32'(nframes));
        for (int k = 0; k < nframes && k < ncap[g] - k0; k++) begin
            el = (2 * k < n) ? fmem[g][2 * k] : 16'h0000;
            er = (2 * k + 1 < n) ? fmem[g][2 * k + 1] : 16'h0000;
            chk("frame", cap[g][(k0 + k) % 256], {el, er});
        end
        chk("underrun", 32'(underrun[g]), 32'(n < attempts));
        en[g] = 1'b0;
        step();
        sample();
        chk("idle_out", 32'({fifo_rd[g], tick[g], dac_bck[g], dac_lrck[g], dac_dat[g]}), 0);
    endtask

    // Drops en at bit slot 10, then re-enables and times the first tick.
    task automatic en_drop(input int g);
        int d, c0, c1, t0, r0, target;
        d = (g == 0) ? DIV0 : DIV1;
        load(g, 16, 1'b0);
        en[g] = 1'b1;
        c0 = cyc;
        target = c0 + 5 + 20 * d + 1;
        repeat (target - cyc) step();
        en[g] = 1'b0;
        sample();
        chk("lrck_mid", 32'(dac_lrck[g]), 0);
        step();
        sample();
        chk("drop_out", 32'({fifo_rd[g], tick[g], dac_bck[g], dac_lrck[g], dac_dat[g]}), 0);
        t0 = tn[g]; r0 = rdn[g];
        repeat (40) step();
        chk("drop_tick", 32'(tn[g] - t0), 0);
        chk("drop_rd", 32'(rdn[g] - r0), 0);
        en[g] = 1'b1;
        c1 = cyc;
        repeat (6) step();
        sample();
        chk("re_tick_cnt", 32'(tn[g] - t0), 1);
        chk("re_tick_at", 32'(tlog[g][t0 % 256]), 32'(c1 + 5));
        en[g] = 1'b0;
        step();
    endtask

    // Reset lands on the RD_R cycle while the read strobe is high.
    task automatic reset_in_rdr();
        load(1, 4, 1'b0);
        en[1] = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        sample();
        chk("rd_in_rdr", 32'(fifo_rd[1]), 1);
        step();
        sample();
        chk("rst_out", 32'({fifo_rd[1], tick[1], dac_bck[1], dac_lrck[1], dac_dat[1], underrun[1]}), 0);
        en[1] = 1'b0;
        reset = 1'b0;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        en = '0;
        underrun_clr = '0;
        repeat (3) step();
        sample();
        for (int g = 0; g < 2; g++)
            chk("reset_out", 32'({fifo_rd[g], tick[g], dac_bck[g], dac_lrck[g], dac_dat[g], underrun[g]}), 0);
        reset = 1'b0;
        step();

        run_stream(0, 2, 2, 1'b1, 1'b0);
        run_stream(0, 0, 1, 1'b0, 1'b1);
        run_stream(1, 8, 4, 1'b0, 1'b0);
        run_stream(0, 3, 2, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            run_stream($urandom_range(0, 1), $urandom_range(0, 12), $urandom_range(1, 3),
                       1'b0, 1'($urandom_range(0, 1)));
        en_drop(0);
        en_drop(1);
        reset_in_rdr();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
